// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencing stage.
// Contents: default widths, 3-bit state encodings and the FSM state type,
// and the ALU opcode constants used by the external combinational ALU.
package uart_alu_pkg;

    localparam int NB_BITS_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_OP = 3'd1;
    localparam logic [2:0] ST_WAIT_B  = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    typedef enum logic [2:0] {
        WAIT_A  = ST_WAIT_A,
        WAIT_OP = ST_WAIT_OP,
        WAIT_B  = ST_WAIT_B,
        SEND    = ST_SEND,
        WAIT_TX = ST_WAIT_TX
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface_tmo_counter.sv
// Inter-byte timeout counter.
// Ports:
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_clr     clear count to zero (has priority over i_en)
//   i_en      count one cycle
//   o_expire  count has reached TIMEOUT-1 while enabled; never set when TIMEOUT=0
// The count saturates at TIMEOUT-1 instead of wrapping.
module tmo_counter #(
    parameter int NB_TMO  = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [NB_TMO-1:0] TC = (TIMEOUT == 0) ? '0 : NB_TMO'(TIMEOUT - 1);

    logic [NB_TMO-1:0] count_q;
    logic [NB_TMO-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en && (count_q != TC)) begin
            count_d = count_q + NB_TMO'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_en && (count_q == TC);

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between UART receiver and transmitter: gathers operand A,
// opcode and operand B, presents them to the external ALU, then hands the
// ALU result to the transmitter with a start/done handshake.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_rx_data, i_rx_done  received byte and its one-cycle strobe
//   i_alu_result          combinational ALU output
//   i_tx_done             transmitter frame-complete pulse
//   o_alu_a/o_alu_b/o_alu_op  registered ALU operands and opcode
//   o_tx_data, o_tx_start     registered result byte and one-cycle send request
//   o_drop                    one-cycle pulse: byte discarded or command timed out
//
// state   | meaning
// WAIT_A  | idle, next byte is operand A
// WAIT_OP | next byte is the opcode (timeout armed)
// WAIT_B  | next byte is operand B (timeout armed)
// SEND    | one cycle: latch ALU result, request transmit
// WAIT_TX | waiting for transmitter to finish
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int NB_BITS = NB_BITS_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int NB_TMO  = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_BITS-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_BITS-1:0] o_alu_a,
    output logic [NB_BITS-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_BITS-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_drop
);

    state_t             state_q,    state_d;
    logic [NB_BITS-1:0] alu_a_q,    alu_a_d;
    logic [NB_BITS-1:0] alu_b_q,    alu_b_d;
    logic [NB_OP-1:0]   alu_op_q,   alu_op_d;
    logic [NB_BITS-1:0] tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               drop_q,     drop_d;

    logic in_gather;
    logic tmo_clr;
    logic tmo_expire;

    // Counter runs only while waiting for opcode or B. Holding it clear
    // everywhere else gives a zero count on entry to WAIT_OP, and clearing
    // on any received byte restarts it for the next field.
    assign in_gather = (state_q == WAIT_OP) || (state_q == WAIT_B);
    assign tmo_clr   = !in_gather || i_rx_done;

    tmo_counter #(
        .NB_TMO  (NB_TMO),
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (tmo_clr),
        .i_en     (in_gather),
        .o_expire (tmo_expire)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        drop_d     = 1'b0;

        unique case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                // A byte landing on the expiry cycle wins over the timeout.
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = WAIT_B;
                end else if (tmo_expire) begin
                    drop_d  = 1'b1;
                    state_d = WAIT_A;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = SEND;
                end else if (tmo_expire) begin
                    drop_d  = 1'b1;
                    state_d = WAIT_A;
                end
            end
            SEND: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                drop_d     = i_rx_done;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                drop_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            drop_q     <= drop_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with TIMEOUT=100 and a small
// behavioural ALU driven from the DUT's registered operands.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_drop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    uart_alu_interface #(
        .NB_BITS (8),
        .NB_OP   (6),
        .NB_TMO  (20),
        .TIMEOUT (100)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_drop       (o_drop)
    );

    // External ALU model
    always_comb begin
        case (o_alu_op)
            OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
            OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
            OP_AND:  i_alu_result = o_alu_a & o_alu_b;
            OP_OR:   i_alu_result = o_alu_a | o_alu_b;
            OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
            OP_SRA:  i_alu_result = $unsigned($signed(o_alu_a) >>> o_alu_b);
            OP_SRL:  i_alu_result = o_alu_a >> o_alu_b;
            OP_NOR:  i_alu_result = ~(o_alu_a | o_alu_b);
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic tx_done();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(o_alu_a),    32'h0);
        check({tag, "_b"},     32'(o_alu_b),    32'h0);
        check({tag, "_op"},    32'(o_alu_op),   32'h0);
        check({tag, "_txd"},   32'(o_tx_data),  32'h0);
        check({tag, "_start"}, 32'(o_tx_start), 32'h0);
        check({tag, "_drop"},  32'(o_drop),     32'h0);
    endtask

    initial begin
        logic saw_drop;
        i_rst     = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        check_all_zero("reset");

        // Basic ADD: 0x53 + 0x01
        rx(8'h53);
        check("add_a", 32'(o_alu_a), 32'h53);
        rx(8'h20);
        check("add_op", 32'(o_alu_op), 32'h20);
        rx(8'h01);                                   // now at t+1
        check("add_b", 32'(o_alu_b), 32'h01);
        check("add_start_t1", 32'(o_tx_start), 32'h0);
        step();                                      // t+2
        check("add_start_t2", 32'(o_tx_start), 32'h1);
        check("add_txd", 32'(o_tx_data), 32'h54);
        step();                                      // t+3
        check("add_start_t3", 32'(o_tx_start), 32'h0);
        tx_done();

        // Opcode masking: 0xE2 -> SUB, 0x10 - 0x03
        rx(8'h10);
        check("mask_a", 32'(o_alu_a), 32'h10);
        rx(8'hE2);
        check("mask_op", 32'(o_alu_op), 32'h22);
        rx(8'h03);
        step();                                      // t+2, WAIT_TX
        check("mask_start", 32'(o_tx_start), 32'h1);
        check("mask_txd", 32'(o_tx_data), 32'h0D);

        // Busy drop: byte during WAIT_TX is discarded
        rx(8'h77);
        check("busy_drop", 32'(o_drop), 32'h1);
        check("busy_a_kept", 32'(o_alu_a), 32'h10);
        step();
        check("busy_drop_pulse", 32'(o_drop), 32'h0);
        tx_done();
        rx(8'h05);
        check("busy_next_a", 32'(o_alu_a), 32'h05);
        rx(8'h20);
        rx(8'h05);
        step();
        check("busy_next_start", 32'(o_tx_start), 32'h1);
        check("busy_next_txd", 32'(o_tx_data), 32'h0A);
        tx_done();

        // Timeout after A only: first WAIT_OP cycle has count 0, expiry at count 99
        rx(8'h11);
        saw_drop = 1'b0;
        for (int i = 0; i < 99; i++) begin
            step();
            saw_drop = saw_drop | o_drop;
        end
        check("tmo_no_early_drop", 32'(saw_drop), 32'h0);
        step();
        check("tmo_drop", 32'(o_drop), 32'h1);
        step();
        check("tmo_drop_pulse", 32'(o_drop), 32'h0);
        rx(8'h21);
        check("tmo_next_a", 32'(o_alu_a), 32'h21);
        check("tmo_op_stale", 32'(o_alu_op), 32'h20);
        rx(8'h20);
        rx(8'h02);
        step();
        check("tmo_next_txd", 32'(o_tx_data), 32'h23);
        tx_done();

        // Byte on the exact expiry cycle is accepted
        rx(8'h30);
        for (int i = 0; i < 99; i++) step();
        rx(8'h20);
        check("edge_no_drop", 32'(o_drop), 32'h0);
        check("edge_op", 32'(o_alu_op), 32'h20);
        saw_drop = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            saw_drop = saw_drop | o_drop;
        end
        check("edge_cleared", 32'(saw_drop), 32'h0);
        rx(8'h01);
        step();
        check("edge_txd", 32'(o_tx_data), 32'h31);
        tx_done();

        // SRL
        rx(8'h80);
        rx(8'h02);
        rx(8'h03);
        step();
        check("srl_txd", 32'(o_tx_data), 32'h10);
        tx_done();

        // Reset mid-command
        rx(8'h40);
        rx(8'h22);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_all_zero("rst_mid");
        rx(8'h09);
        check("rst_mid_a", 32'(o_alu_a), 32'h09);
        rx(8'h22);
        check("rst_mid_op", 32'(o_alu_op), 32'h22);
        rx(8'h04);
        step();
        check("rst_mid_start", 32'(o_tx_start), 32'h1);
        check("rst_mid_txd", 32'(o_tx_data), 32'h05);

        // Reset during WAIT_TX, then a stray i_tx_done
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check("rst_tx_start", 32'(o_tx_start), 32'h0);
        check("rst_tx_txd", 32'(o_tx_data), 32'h0);
        tx_done();
        check("rst_tx_stray_start", 32'(o_tx_start), 32'h0);
        rx(8'h07);
        check("rst_tx_a", 32'(o_alu_a), 32'h07);
        tx_done();                                   // ignored in WAIT_OP
        rx(8'h20);
        check("rst_tx_op", 32'(o_alu_op), 32'h20);
        rx(8'h01);
        check("rst_tx_b", 32'(o_alu_b), 32'h01);
        step();
        check("rst_tx_start2", 32'(o_tx_start), 32'h1);
        check("rst_tx_txd2", 32'(o_tx_data), 32'h08);
        tx_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
